alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk (in, 1, rising-edge clock) and reset (in, 1, synchronous active-high reset).
REQ-002 For each requester n in {0,1}, the block SHALL have the following ports:
- reqn_valid (in, 1): request present.
- reqn_ready (out, 1): request accepted this cycle.
- reqn_opc (in, 4): ALU opcode.
- reqn_sel_pc (in, 1): first operand select, 1 = PC, 0 = reg1.
- reqn_pc (in, 32): PC operand.
- reqn_reg1 (in, 32): first register operand.
- reqn_src2 (in, 32): second operand.
REQ-003 The ALU-side ports SHALL be:
- alu_opc (out, 4).
- alu_sel_pc (out, 1).
- alu_pc (out, 32).
- alu_reg1 (out, 32).
- alu_src2 (out, 32).
- alu_result (in, 32): combinational result of the shared ALU.
REQ-004 The response ports SHALL be:
- rsp_valid (out, 1).
- rsp_ready (in, 1).
- rsp_id (out, 1): requester index.
- rsp_data (out, 32).
- rsp_err (out, 1): opcode was illegal.
- busy (out, 1): state is not IDLE.

Function
REQ-005 The block SHALL implement the states IDLE, EXEC and RESP, encoded as a registered FSM.
REQ-006 In IDLE with at least one reqn_valid asserted, the block SHALL grant one requester:
- If only one requester is valid, grant that requester.
- If both are valid, grant the requester indicated by the round-robin pointer rr.
REQ-007 reqn_ready SHALL be asserted combinationally only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
REQ-008 On a grant, the block SHALL capture opc, sel_pc, pc, reg1, src2 and the granted index into operand registers, set rr to the non-granted index, and move to EXEC.
REQ-009 alu_opc, alu_sel_pc, alu_pc, alu_reg1 and alu_src2 SHALL be driven directly from the operand registers in all states.
REQ-010 In EXEC, the block SHALL register rsp_data <= alu_result, rsp_id <= captured index and rsp_err <= (captured opc not in {0000,1000,0111,0110,0100,0010,0011,0001,0101,1101}), then move to RESP.
REQ-011 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_id and rsp_err SHALL remain stable until the cycle in which rsp_ready=1.
REQ-012 In the RESP cycle with rsp_ready=1, the block SHALL return to IDLE; rsp_valid SHALL be 0 from the next cycle, and no new grant SHALL occur in that same cycle.
REQ-013 Latency SHALL be fixed: a request accepted in cycle N SHALL produce rsp_valid=1 in cycle N+2, and the minimum issue interval SHALL be 3 cycles.
REQ-014 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-015 busy SHALL be 1 in EXEC and RESP.
REQ-016 A requester asserting valid while not granted SHALL see reqn_ready=0; the block SHALL place no obligation on a requester that deasserts valid before ready.
REQ-017 Changes on reqn_* inputs after acceptance SHALL NOT affect the in-flight operation.
REQ-018 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-019 rsp_ready asserted outside RESP SHALL be ignored.
REQ-020 Requests arriving during EXEC or RESP SHALL be held off (ready=0) and arbitrated in the next IDLE cycle using the updated rr.
REQ-021 With a persistent requester, the fairness bound SHALL hold: a requester continuously valid SHALL be granted within 2 grants.

Reset
REQ-022 On reset=1 at a rising clk edge, the block SHALL set:
- state = IDLE.
- rr = 0.
- rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0.
- all operand registers (hence all alu_* outputs) = 0.
- busy = 0.
REQ-023 During reset, req0_ready and req1_ready SHALL be 0.
REQ-024 Reset asserted in EXEC or RESP SHALL abort the operation with no response issued, and the first post-reset grant SHALL follow REQ-006 with rr=0.

Verification
REQ-025 The bench SHALL drive the shared ALU with a reference RV32I ALU model and cover these directed scenarios:
- Single request: req0 AND with reg1=0xF0F0F0F0, src2=0x0FF00FF0, sel_pc=0 accepted in cycle N -> rsp_valid in N+2, rsp_data=0x00F000F0, rsp_id=0, rsp_err=0.
- Simultaneous requests after reset: req0 XOR (0xFFFF0000, 0x0F0F0F0F) and req1 OR (0x1, 0x2) both valid continuously, rsp_ready=1 -> first response rsp_id=0, data=0xF0F00F0F; second response rsp_id=1, data=0x00000003.
- Response backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable for all 5 cycles, both ready signals 0, busy=1; rsp_ready=1 -> IDLE on the next cycle.
- Illegal opcode: req1 opc=4'b1111 -> rsp_err=1, rsp_data = alu_result (0x00000000 from the reference model), rsp_id=1.
- Reset mid-operation: reset asserted in the EXEC cycle -> the next cycle shows rsp_valid=0, busy=0, alu_* outputs=0, with no response ever issued for that request.
- Fairness and isolation: req0 continuously valid and req1 valid once -> req1 granted no later than the second grant; changing req0_reg1 after acceptance does not alter rsp_data.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of its environment.
interface alu_arbiter_if;
  logic        req0_valid, req0_ready, req0_sel_pc;
  logic [3:0]  req0_opc;
  logic [31:0] req0_pc, req0_reg1, req0_src2;
  logic        req1_valid, req1_ready, req1_sel_pc;
  logic [3:0]  req1_opc;
  logic [31:0] req1_pc, req1_reg1, req1_src2;
  logic [3:0]  alu_opc;
  logic        alu_sel_pc;
  logic [31:0] alu_pc, alu_reg1, alu_src2, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data;

  modport slave (
    input  req0_valid, req0_opc, req0_sel_pc, req0_pc, req0_reg1, req0_src2,
    input  req1_valid, req1_opc, req1_sel_pc, req1_pc, req1_reg1, req1_src2,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_opc, alu_sel_pc, alu_pc, alu_reg1, alu_src2,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_opc, req0_sel_pc, req0_pc, req0_reg1, req0_src2,
    output req1_valid, req1_opc, req1_sel_pc, req1_pc, req1_reg1, req1_src2,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_opc, alu_sel_pc, alu_pc, alu_reg1, alu_src2,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that sequences one shared combinational ALU.
// Each operation is IDLE (grant) -> EXEC (ALU evaluates) -> RESP (held until taken).
module alu_arbiter (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rr, r_id, r_sel_pc, r_rsp_id, r_rsp_err;
  logic [3:0]  r_opc;
  logic [31:0] r_pc, r_reg1, r_src2, r_rsp_data;
  logic        w_gnt_valid, w_gnt_id, w_opc_legal;

  // Grant only in IDLE and never while reset is asserted.
  always_comb begin
    // NOTE: every combinational output is assigned a default first so no path can infer a latch.
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (r_state == IDLE && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = r_rr;
      end else if (bus.req0_valid) begin
        w_gnt_valid = 1'b1;
      end else if (bus.req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b1;
      end
    end
  end

  always_comb begin
    w_opc_legal = 1'b0;
    case (r_opc)
      4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
      4'b0010, 4'b0011, 4'b0001, 4'b0101, 4'b1101: w_opc_legal = 1'b1;
      default:                                     w_opc_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic. rsp_valid depends only on registered state.
  always_comb begin
    bus.req0_ready = w_gnt_valid && !w_gnt_id;
    bus.req1_ready = w_gnt_valid &&  w_gnt_id;
    bus.rsp_valid  = (r_state == RESP);
    bus.busy       = (r_state != IDLE);
  end

  // Operand capture on grant, and response capture in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr       <= 1'b0;
      r_id       <= 1'b0;
      r_opc      <= 4'd0;
      r_sel_pc   <= 1'b0;
      r_pc       <= 32'd0;
      r_reg1     <= 32'd0;
      r_src2     <= 32'd0;
      r_rsp_data <= 32'd0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_gnt_valid) begin
        r_id     <= w_gnt_id;
        r_rr     <= ~w_gnt_id;
        r_opc    <= w_gnt_id ? bus.req1_opc    : bus.req0_opc;
        r_sel_pc <= w_gnt_id ? bus.req1_sel_pc : bus.req0_sel_pc;
        r_pc     <= w_gnt_id ? bus.req1_pc     : bus.req0_pc;
        r_reg1   <= w_gnt_id ? bus.req1_reg1   : bus.req0_reg1;
        r_src2   <= w_gnt_id ? bus.req1_src2   : bus.req0_src2;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= bus.alu_result;
        r_rsp_id   <= r_id;
        r_rsp_err  <= ~w_opc_legal;
      end
    end
  end

  assign bus.alu_opc    = r_opc;
  assign bus.alu_sel_pc = r_sel_pc;
  assign bus.alu_pc     = r_pc;
  assign bus.alu_reg1   = r_reg1;
  assign bus.alu_src2   = r_src2;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_err    = r_rsp_err;

endmodule
